// File: rtl/window_scan_ctrl_if.sv
// Pixel-stream handshake and coordinate bundle between an upstream raster source
// and window_scan_ctrl.
interface window_scan_ctrl_if #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic          pixel_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  modport master (output in_valid, input in_ready, input pixel_valid, input x, input y);
  modport slave  (input in_valid, output in_ready, output pixel_valid, output x, output y);
endinterface

// File: rtl/window_scan_ctrl.sv
// Frame-scan sequencer for the 3x3 line-buffer / sliding-window datapath.
// Optional macro SWCTRL_HBLANK_EN inserts H_BLANK idle cycles after every non-final row.
module window_scan_ctrl #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned XW    = 11,
  parameter int unsigned YW    = 10
`ifdef SWCTRL_HBLANK_EN
  , parameter int unsigned H_BLANK = 4
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  window_scan_ctrl_if.slave   pix,
  output logic                lb_wr_en,
  output logic [1:0]          lb_wr_sel,
  output logic [1:0]          lb_rd_rot,
  output logic                win_valid,
  output logic [XW-1:0]       win_x,
  output logic [YW-1:0]       win_y,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef SWCTRL_HBLANK_EN
    , S_HBLANK = 2'd3
`endif
  } state_e;

`ifdef SWCTRL_HBLANK_EN
  localparam int unsigned BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  logic [BW-1:0] blank_q, blank_d;
`endif

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, win_x_q;
  logic [YW-1:0] y_q, y_d, win_y_q;
  logic [1:0]    sel_q, sel_d, rot_q, rot_d;
  logic          in_ready_q, busy_q, frame_done_q, win_valid_q;
  logic          pv_c, last_col_c, last_row_c;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign pv_c       = pix.in_valid && in_ready_q;
  assign last_col_c = (x_q == XW'(IMG_W - 1));
  assign last_row_c = (y_q == YW'(IMG_H - 1));

  // Next-state, counter and bank-rotation logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    rot_d   = rot_q;
`ifdef SWCTRL_HBLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = '0;
          sel_d   = 2'd0;
          rot_d   = 2'd1;
        end
      end
      S_RUN: begin
        if (pv_c) begin
          if (last_col_c) begin
            sel_d = inc3(sel_q);
            rot_d = inc3(inc3(sel_q));
            if (last_row_c) begin
              state_d = S_DONE;
            end else begin
              x_d = '0;
              y_d = y_q + YW'(1);
`ifdef SWCTRL_HBLANK_EN
              state_d = S_HBLANK;
              blank_d = '0;
`endif
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
`ifdef SWCTRL_HBLANK_EN
      S_HBLANK: begin
        blank_d = blank_q + BW'(1);
        if (blank_q == BW'(H_BLANK - 1)) state_d = S_RUN;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sel_q        <= 2'd0;
      rot_q        <= 2'd0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SWCTRL_HBLANK_EN
      blank_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sel_q        <= sel_d;
      rot_q        <= rot_d;
      in_ready_q   <= (state_d == S_RUN);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
`ifdef SWCTRL_HBLANK_EN
      blank_q      <= blank_d;
`endif
    end
  end

  // Window qualifier aligned with the one-stage sliding-window register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      win_valid_q <= pv_c && (x_q >= XW'(2)) && (y_q >= YW'(2));
      if (pv_c) begin
        win_x_q <= x_q - XW'(1);
        win_y_q <= y_q - YW'(1);
      end
    end
  end

  assign pix.in_ready    = in_ready_q;
  assign pix.pixel_valid = pv_c;
  assign pix.x           = x_q;
  assign pix.y           = y_q;
  assign lb_wr_en        = pv_c;
  assign lb_wr_sel       = sel_q;
  assign lb_rd_rot       = rot_q;
  assign win_valid       = win_valid_q;
  assign win_x           = win_x_q;
  assign win_y           = win_y_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: three frame geometries driven in lockstep against a
// pixel-index reference model, plus a cycle table for the 4x3 frame.
module tb_window_scan_ctrl;

`ifdef SWCTRL_HBLANK_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif

  logic clk, reset, start, in_valid;

  window_scan_ctrl_if #(.XW(11), .YW(10)) ifa ();
  window_scan_ctrl_if #(.XW(11), .YW(10)) ifb ();
  window_scan_ctrl_if #(.XW(11), .YW(10)) ifc ();

  assign ifa.in_valid = in_valid;
  assign ifb.in_valid = in_valid;
  assign ifc.in_valid = in_valid;

  logic [2:0]       wen_v, wv_v, busy_v, fd_v;
  logic [2:0][1:0]  sel_v, rot_v;
  logic [2:0][10:0] wx_v;
  logic [2:0][9:0]  wy_v;

  window_scan_ctrl #(.IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pix(ifa.slave),
    .lb_wr_en(wen_v[0]), .lb_wr_sel(sel_v[0]), .lb_rd_rot(rot_v[0]), .win_valid(wv_v[0]),
    .win_x(wx_v[0]), .win_y(wy_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
  window_scan_ctrl #(.IMG_W(5), .IMG_H(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pix(ifb.slave),
    .lb_wr_en(wen_v[1]), .lb_wr_sel(sel_v[1]), .lb_rd_rot(rot_v[1]), .win_valid(wv_v[1]),
    .win_x(wx_v[1]), .win_y(wy_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
  window_scan_ctrl #(.IMG_W(3), .IMG_H(5)) dut_c (
    .clk(clk), .reset(reset), .start(start), .pix(ifc.slave),
    .lb_wr_en(wen_v[2]), .lb_wr_sel(sel_v[2]), .lb_rd_rot(rot_v[2]), .win_valid(wv_v[2]),
    .win_x(wx_v[2]), .win_y(wy_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

  logic [2:0] rdy_v, pv_v;
  int         ox[3], oy[3];
  assign rdy_v = {ifc.in_ready, ifb.in_ready, ifa.in_ready};
  assign pv_v  = {ifc.pixel_valid, ifb.pixel_valid, ifa.pixel_valid};
  assign ox[0] = int'(ifa.x);
  assign ox[1] = int'(ifb.x);
  assign ox[2] = int'(ifc.x);
  assign oy[0] = int'(ifa.y);
  assign oy[1] = int'(ifb.y);
  assign oy[2] = int'(ifc.y);

  // Reference model: phase 0 idle, 1 run, 2 blank, 3 done; n = pixels accepted this frame
  int W[3] = '{4, 5, 3};
  int H[3] = '{3, 4, 5};
  int ph[3], n[3], bc[3], mwv[3], mwx[3], mwy[3], wcount[3];
  int errors = 0, checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; n[i] = 0; bc[i] = 0;
      mwv[i] = 0; mwx[i] = 0; mwy[i] = 0; wcount[i] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_x[%0d]", tag, i), 32'(ox[i]), 0);
      check($sformatf("%s_y[%0d]", tag, i), 32'(oy[i]), 0);
      check($sformatf("%s_sel[%0d]", tag, i), 32'(sel_v[i]), 0);
      check($sformatf("%s_rot[%0d]", tag, i), 32'(rot_v[i]), 0);
      check($sformatf("%s_wx[%0d]", tag, i), 32'(wx_v[i]), 0);
      check($sformatf("%s_wy[%0d]", tag, i), 32'(wy_v[i]), 0);
      check($sformatf("%s_flags[%0d]", tag, i),
            32'({rdy_v[i], wv_v[i], busy_v[i], fd_v[i]}), 0);
    end
  endtask

  // One clock: drive inputs, check the combinational enable, clock, advance model, check outputs
  task automatic step(input logic st, input logic iv);
    int pv[3];
    int k, row, wh;
    start = st;
    in_valid = iv;
    #1;
    for (int i = 0; i < 3; i++) begin
      pv[i] = (iv && ph[i] == 1) ? 1 : 0;
      check($sformatf("pixel_valid[%0d]", i), 32'(pv_v[i]), 32'(pv[i]));
      check($sformatf("lb_wr_en[%0d]", i), 32'(wen_v[i]), 32'(pv[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      k = n[i];
      wh = W[i] * H[i];
      mwv[i] = (pv[i] == 1 && (k % W[i]) >= 2 && (k / W[i]) >= 2) ? 1 : 0;
      if (pv[i] == 1) begin
        mwx[i] = ((k % W[i]) + 2047) % 2048;
        mwy[i] = ((k / W[i]) + 1023) % 1024;
      end
      case (ph[i])
        0: if (st) begin ph[i] = 1; n[i] = 0; end
        1: if (pv[i] == 1) begin
             n[i]++;
             if (n[i] == wh) ph[i] = 3;
             else if (HB > 0 && n[i] % W[i] == 0) begin ph[i] = 2; bc[i] = 0; end
           end
        2: begin bc[i]++; if (bc[i] == HB) ph[i] = 1; end
        default: ph[i] = 0;
      endcase
      check($sformatf("in_ready[%0d]", i), 32'(rdy_v[i]), 32'(ph[i] == 1));
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(ph[i] != 0));
      check($sformatf("frame_done[%0d]", i), 32'(fd_v[i]), 32'(ph[i] == 3));
      check($sformatf("x[%0d]", i), 32'(ox[i]), 32'((n[i] >= wh) ? W[i] - 1 : n[i] % W[i]));
      check($sformatf("y[%0d]", i), 32'(oy[i]), 32'((n[i] >= wh) ? H[i] - 1 : n[i] / W[i]));
      check($sformatf("win_valid[%0d]", i), 32'(wv_v[i]), 32'(mwv[i]));
      check($sformatf("win_x[%0d]", i), 32'(wx_v[i]), 32'(mwx[i]));
      check($sformatf("win_y[%0d]", i), 32'(wy_v[i]), 32'(mwy[i]));
      if (ph[i] == 1 || ph[i] == 2) begin
        row = n[i] / W[i];
        check($sformatf("lb_wr_sel[%0d]", i), 32'(sel_v[i]), 32'(row % 3));
        check($sformatf("lb_rd_rot[%0d]", i), 32'(rot_v[i]), 32'((row + 1) % 3));
      end
      if (wv_v[i] === 1'b1) wcount[i]++;
    end
  endtask

  task automatic run_to_idle(input bit rnd);
    int cyc = 0;
    while (!(ph[0] == 0 && ph[1] == 0 && ph[2] == 0) && cyc < 3000) begin
      step(1'b0, rnd ? 1'($urandom % 2) : 1'b1);
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL run_to_idle: still busy after %0d cycles, expected idle", cyc);
    end
  endtask

  task automatic check_win_counts(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_wincount[%0d]", tag, i), 32'(wcount[i]), 32'((W[i] - 2) * (H[i] - 2)));
      wcount[i] = 0;
    end
  endtask

  typedef struct {
    logic st, iv, rdy;
    int   x, y;
    logic wv;
    int   wx, wy;
    logic fd, busy;
  } vec_t;

  initial begin
    vec_t tv[16];
    int   cyc;
    tv[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[1]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    tv[2]  = '{0, 1, 1, 2, 0, 0, 0, 0, 0, 1};
    tv[3]  = '{0, 1, 1, 3, 0, 0, 0, 0, 0, 1};
    tv[4]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 1};
    tv[5]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
    tv[6]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    tv[7]  = '{0, 1, 1, 2, 1, 0, 0, 0, 0, 1};
    tv[8]  = '{0, 1, 1, 3, 1, 0, 0, 0, 0, 1};
    tv[9]  = '{0, 1, 1, 0, 2, 0, 0, 0, 0, 1};
    tv[10] = '{0, 1, 1, 1, 2, 0, 0, 0, 0, 1};
    tv[11] = '{0, 1, 1, 2, 2, 0, 0, 0, 0, 1};
    tv[12] = '{0, 1, 1, 3, 2, 1, 1, 1, 0, 1};
    tv[13] = '{0, 1, 0, 3, 2, 1, 2, 1, 1, 1};
    tv[14] = '{1, 1, 0, 3, 2, 0, 0, 0, 0, 0};
    tv[15] = '{0, 0, 0, 3, 2, 0, 0, 0, 0, 0};

    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("por");

`ifndef SWCTRL_HBLANK_EN
    // Cycle table for the 4x3 frame (dut_a); start in tv[14] lands on DONE->IDLE
    for (int t = 0; t < 16; t++) begin
      step(tv[t].st, tv[t].iv);
      check($sformatf("tv%0d_rdy", t), 32'(rdy_v[0]), 32'(tv[t].rdy));
      check($sformatf("tv%0d_x", t), 32'(ox[0]), 32'(tv[t].x));
      check($sformatf("tv%0d_y", t), 32'(oy[0]), 32'(tv[t].y));
      check($sformatf("tv%0d_wv", t), 32'(wv_v[0]), 32'(tv[t].wv));
      check($sformatf("tv%0d_fd", t), 32'(fd_v[0]), 32'(tv[t].fd));
      check($sformatf("tv%0d_busy", t), 32'(busy_v[0]), 32'(tv[t].busy));
      if (tv[t].wv) begin
        check($sformatf("tv%0d_wx", t), 32'(wx_v[0]), 32'(tv[t].wx));
        check($sformatf("tv%0d_wy", t), 32'(wy_v[0]), 32'(tv[t].wy));
      end
    end
`else
    step(1'b1, 1'b0);
`endif
    run_to_idle(1'b0);
    check_win_counts("f0");

    // Randomised in_valid gaps over two frames
    for (int f = 0; f < 2; f++) begin
      step(1'b1, 1'($urandom % 2));
      run_to_idle(1'b1);
      check_win_counts($sformatf("rnd%0d", f));
    end

    // Asynchronous reset mid-frame once dut_b reaches row 2, x = 1
    step(1'b1, 1'b0);
    cyc = 0;
    while (n[1] != 11 && cyc < 200) begin
      step(1'b0, 1'b1);
      cyc++;
    end
    check("midreset_reach_b_x", 32'(ox[1]), 1);
    check("midreset_reach_b_y", 32'(oy[1]), 2);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midreset_hold_fd", 32'(fd_v), 0);
      check("midreset_hold_busy", 32'(busy_v), 0);
    end
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b1);
    run_to_idle(1'b1);
    check_win_counts("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
